// File: rtl/engine_return_collector.sv
// Collects per-engine done pulses and return codes into a FWFT FIFO of 41-bit records.
// Optional transfer counter output stat_records_o is enabled by defining ERC_STATS_EN.
module engine_return_collector #(
    parameter int KERNEL_NUM = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [KERNEL_NUM-1:0]         engine_done_i,
    input  logic [32*KERNEL_NUM-1:0]      engine_rc_i,
    output logic                          complete_push_o,
    input  logic                          complete_ready_i,
    output logic [40:0]                   return_data_o,
    output logic                          lost_sticky_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
`ifdef ERC_STATS_EN
    ,
    output logic [31:0]                   stat_records_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;

    logic [KERNEL_NUM-1:0] pending_q, pending_d;
    logic [KERNEL_NUM-1:0] lost_q, lost_d;
    logic [31:0]           rc_q [KERNEL_NUM];
    logic [31:0]           rc_d [KERNEL_NUM];
    logic [IW-1:0]         rr_q, rr_d;
    logic                  sticky_q, sticky_d;
    logic [40:0]           mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;

    logic                  full_s;
    logic                  empty_s;
    logic                  pop_s;
    logic                  grant_s;
    logic [IW-1:0]         grant_idx_s;
    logic [40:0]           wr_data_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_s   = !empty_s && complete_ready_i;

    // Round-robin search starting one past the last granted engine.
    always_comb begin
        int cand;
        logic [IW-1:0] cand_idx;
        grant_s     = 1'b0;
        grant_idx_s = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < KERNEL_NUM; i++) begin
            cand     = (int'(rr_q) + 1 + i) % KERNEL_NUM;
            cand_idx = IW'(cand);
            if (!grant_s && !full_s && pending_q[cand_idx]) begin
                grant_s     = 1'b1;
                grant_idx_s = cand_idx;
            end else begin
                grant_s     = grant_s;
            end
        end
    end

    assign wr_data_s = {lost_q[grant_idx_s], 8'(grant_idx_s), rc_q[grant_idx_s]};

    // Capture, collision and grant bookkeeping per engine.
    always_comb begin
        logic gk;
        pending_d = pending_q;
        lost_d    = lost_q;
        rc_d      = rc_q;
        sticky_d  = sticky_q;
        gk        = 1'b0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            gk = grant_s && (grant_idx_s == IW'(k));
            if (engine_done_i[k]) begin
                // A grant in the same cycle frees the slot, so the new code is kept.
                if (!pending_q[k] || gk) begin
                    pending_d[k] = 1'b1;
                    rc_d[k]      = engine_rc_i[32*k +: 32];
                    lost_d[k]    = 1'b0;
                end else begin
                    lost_d[k]    = 1'b1;
                    sticky_d     = 1'b1;
                end
            end else if (gk) begin
                pending_d[k] = 1'b0;
                lost_d[k]    = 1'b0;
            end else begin
                pending_d[k] = pending_q[k];
            end
        end
    end

    // Pointer and arbiter next-state.
    always_comb begin
        wr_ptr_d = grant_s ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d = pop_s   ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
        rr_d     = grant_s ? grant_idx_s : rr_q;
    end

    // Engine-side state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            lost_q    <= '0;
            sticky_q  <= 1'b0;
            rr_q      <= IW'(KERNEL_NUM - 1);
            for (int k = 0; k < KERNEL_NUM; k++) begin
                rc_q[k] <= 32'h0000_0000;
            end
        end else begin
            pending_q <= pending_d;
            lost_q    <= lost_d;
            sticky_q  <= sticky_d;
            rr_q      <= rr_d;
            rc_q      <= rc_d;
        end
    end

    // Record FIFO storage and pointers; storage is cleared so outputs read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int d = 0; d < FIFO_DEPTH; d++) begin
                mem_q[d] <= 41'h0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (grant_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_data_s;
            end
        end
    end

    assign complete_push_o = !empty_s;
    assign return_data_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign lost_sticky_o   = sticky_q;
    assign fifo_level_o    = wr_ptr_q - rd_ptr_q;

`ifdef ERC_STATS_EN
    logic [31:0] stat_cnt_q, stat_cnt_d;

    assign stat_cnt_d = pop_s ? (stat_cnt_q + 32'd1) : stat_cnt_q;

    // Transferred-record counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt_q <= 32'h0000_0000;
        end else begin
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign stat_records_o = stat_cnt_q;
`endif

endmodule

// File: tb/tb_engine_return_collector.sv
// Directed bench for engine_return_collector with an expected-record queue.
module tb_engine_return_collector;

    localparam int K = 2;
    localparam int D = 8;

    logic            clk;
    logic            rst_n;
    logic [K-1:0]    engine_done_i;
    logic [32*K-1:0] engine_rc_i;
    logic            complete_push_o;
    logic            complete_ready_i;
    logic [40:0]     return_data_o;
    logic            lost_sticky_o;
    logic [3:0]      fifo_level_o;
`ifdef ERC_STATS_EN
    logic [31:0]     stat_records_o;
`endif

    engine_return_collector #(.KERNEL_NUM(K), .FIFO_DEPTH(D)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .engine_done_i    (engine_done_i),
        .engine_rc_i      (engine_rc_i),
        .complete_push_o  (complete_push_o),
        .complete_ready_i (complete_ready_i),
        .return_data_o    (return_data_o),
        .lost_sticky_o    (lost_sticky_o),
        .fifo_level_o     (fifo_level_o)
`ifdef ERC_STATS_EN
        ,
        .stat_records_o   (stat_records_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [40:0] exp_q [$];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          xfer_cnt = 0;

    function automatic logic [40:0] rec(input logic lost, input int k, input logic [31:0] rc);
        logic [7:0] kid;
        kid = 8'(k);
        return {lost, kid, rc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called at a negedge after inputs are set: scores any transfer, then advances one cycle.
    task automatic step();
        logic [40:0] e;
        if (complete_push_o && complete_ready_i) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_record", {23'h0, return_data_o}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk("record", {23'h0, return_data_o}, {23'h0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input int k, input logic [31:0] rc, input logic lost_exp);
        engine_done_i = '0;
        engine_done_i[k] = 1'b1;
        engine_rc_i[32*k +: 32] = rc;
        exp_q.push_back(rec(lost_exp, k, rc));
        step();
        engine_done_i = '0;
    endtask

    task automatic drain(input int budget);
        complete_ready_i = 1'b1;
        for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
            step();
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        engine_done_i    = '0;
        engine_rc_i      = '0;
        complete_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_push",  64'(complete_push_o), 64'd0);
        chk("rst_data",  64'(return_data_o),   64'd0);
        chk("rst_lost",  64'(lost_sticky_o),   64'd0);
        chk("rst_level", 64'(fifo_level_o),    64'd0);

        // Single done on kernel 1: visible two clocks later
        pulse(1, 32'h0000_00AB, 1'b0);
        chk("single_lat1_push", 64'(complete_push_o), 64'd0);
        step();
        chk("single_push", 64'(complete_push_o), 64'd1);
        chk("single_data", 64'(return_data_o), 64'h0_01_000000AB);
        step();
        chk("single_after_push", 64'(complete_push_o), 64'd0);

        // Simultaneous done on both kernels
        engine_done_i = 2'b11;
        engine_rc_i   = {32'h0000_0022, 32'h0000_0011};
        exp_q.push_back(rec(1'b0, 0, 32'h11));
        exp_q.push_back(rec(1'b0, 1, 32'h22));
        step();
        engine_done_i = '0;
        step();
        chk("simul_first", 64'(return_data_o), 64'h0_00_00000011);
        step();
        chk("simul_second", 64'(return_data_o), 64'h0_01_00000022);
        step();
        chk("simul_done_push", 64'(complete_push_o), 64'd0);

        // Backpressure: 10 pulses, 8 stored, 2 held pending
        complete_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pulse(i % 2, 32'h100 + 32'(i), 1'b0);
        end
        step();
        chk("bp_level_full", 64'(fifo_level_o), 64'd8);
        step();
        step();
        chk("bp_level_hold", 64'(fifo_level_o), 64'd8);
        drain(40);
        chk("bp_no_loss", 64'(lost_sticky_o), 64'd0);
        chk("bp_level_empty", 64'(fifo_level_o), 64'd0);

        // Collision on kernel 0 while FIFO full
        complete_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pulse(i % 2, 32'h200 + 32'(i), 1'b0);
        end
        step();
        chk("col_full", 64'(fifo_level_o), 64'd8);
        pulse(0, 32'h0000_0AAA, 1'b1);
        engine_done_i = 2'b01;
        engine_rc_i[31:0] = 32'h0000_0BBB;
        step();
        engine_done_i = '0;
        chk("col_sticky", 64'(lost_sticky_o), 64'd1);
        drain(40);
        pulse(0, 32'h0000_0CCC, 1'b0);
        drain(20);

        // Reset mid-stream with 5 records stored
        complete_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse(i % 2, 32'h300 + 32'(i), 1'b0);
        end
        step();
        chk("mid_level5", 64'(fifo_level_o), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_push",   64'(complete_push_o), 64'd0);
        chk("mid_rst_data",   64'(return_data_o),   64'd0);
        chk("mid_rst_sticky", 64'(lost_sticky_o),   64'd0);
        chk("mid_rst_level",  64'(fifo_level_o),    64'd0);
        exp_q.delete();
        xfer_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        complete_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_idle", 64'(complete_push_o), 64'd0);
        end

        // New activity after reset: three transfers
        engine_done_i = 2'b11;
        engine_rc_i   = {32'h0000_0402, 32'h0000_0401};
        exp_q.push_back(rec(1'b0, 0, 32'h401));
        exp_q.push_back(rec(1'b0, 1, 32'h402));
        step();
        engine_done_i = '0;
        drain(20);
        pulse(1, 32'h0000_0403, 1'b0);
        drain(20);
        chk("post_rst_xfers", 64'(xfer_cnt), 64'd3);
`ifdef ERC_STATS_EN
        chk("stats_three", 64'(stat_records_o), 64'd3);
        force dut.stat_cnt_q = 32'hFFFF_FFFF;
        release dut.stat_cnt_q;
        pulse(0, 32'h0000_0500, 1'b0);
        drain(20);
        chk("stats_wrap", 64'(stat_records_o), 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
